// File: rtl/gray_count_pkg.sv
`default_nettype none
// ============================================================================
// Module   : gray_count_pkg
// Purpose  : Shared types and helpers for the Gray count decoder:
//            - state_t : decoder FSM state encoding
//            - gray_bin_bit() : one bit of a Gray-to-binary decode
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package gray_count_pkg;

    // Widest Gray value the decode helper accepts; callers zero-extend.
    localparam int c_GRAY_MAX_W = 32;

    typedef enum logic [1:0] {
        ST_WARMUP = 2'd0,
        ST_TRACK  = 2'd1,
        ST_HOLD   = 2'd2
    } state_t;

    // Binary bit idx is the XOR of every Gray bit at or above idx. With the
    // operand zero-extended, that is the reduction XOR of gray shifted down.
    function automatic logic gray_bin_bit(input logic [c_GRAY_MAX_W-1:0] gray,
                                          input int unsigned             idx);
        return ^(gray >> idx);
    endfunction

endpackage : gray_count_pkg
`default_nettype wire

// File: rtl/gray_count_decoder_gray_sync.sv
`default_nettype none
// ============================================================================
// Module   : gray_sync
// Purpose  : Multi-flop synchronizer bringing an asynchronous Gray count
//            into the clk domain. Gray coding keeps a multi-bit capture safe:
//            only one bit changes per upstream step.
// Ports    : clk     - destination clock
//            rst_    - asynchronous active-low reset, clears the chain
//            gray_in - Gray count, asynchronous to clk
//            gray_s  - last synchronizer stage
// Revision : 1.0 - initial release
// ============================================================================
module gray_sync #(
    parameter int WIDTH       = 4,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             rst_,
    input  logic [WIDTH-1:0] gray_in,
    output logic [WIDTH-1:0] gray_s
);

    logic [WIDTH-1:0] r_sync [SYNC_STAGES];

    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                r_sync[i] <= '0;
            end
        end else begin
            r_sync[0] <= gray_in;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                r_sync[i] <= r_sync[i-1];
            end
        end
    end

    assign gray_s = r_sync[SYNC_STAGES-1];

endmodule : gray_sync
`default_nettype wire

// File: rtl/gray_count_decoder.sv
`default_nettype none
// ============================================================================
// Module   : gray_count_decoder
// Purpose  : Synchronizes an asynchronous Gray count, decodes it to binary
//            and presents count advances as valid/ready beats. Advances that
//            arrive while a beat is stalled are merged (saturating). A running
//            total accumulates every advance regardless of the handshake.
// Ports    : clk       - clock, rising edge
//            rst_      - asynchronous active-low reset
//            gray_in   - Gray count, asynchronous to clk
//            out_ready - consumer accepts the current beat
//            err_clr   - clears the sticky err flag
//            out_valid - out_bin/out_delta hold an unaccepted beat
//            out_bin   - binary value of the latest synchronized count
//            out_delta - saturating count advance since last accepted beat
//            total     - running sum of all advances, modulo 2^TOTAL_W
//            err       - sticky multi-bit Gray transition flag
//            tracking  - high once warm-up has finished
// Config   : GRAY_COUNT_DECODER_ERR_CHECK_EN - builds the multi-bit
//            transition checker; otherwise err is tied low.
// Revision : 1.0 - initial release
// ============================================================================
module gray_count_decoder
    import gray_count_pkg::*;
#(
    parameter int WIDTH       = 4,
    parameter int SYNC_STAGES = 2,
    parameter int TOTAL_W     = 16
) (
    input  logic               clk,
    input  logic               rst_,
    input  logic [WIDTH-1:0]   gray_in,
    input  logic               out_ready,
    input  logic               err_clr,
    output logic               out_valid,
    output logic [WIDTH-1:0]   out_bin,
    output logic [WIDTH-1:0]   out_delta,
    output logic [TOTAL_W-1:0] total,
    output logic               err,
    output logic               tracking
);

    localparam int                 c_CNT_W     = $clog2(SYNC_STAGES + 1);
    localparam logic [c_CNT_W-1:0] c_WARM_LAST = c_CNT_W'(SYNC_STAGES);
    localparam logic [WIDTH-1:0]   c_SAT       = '1;

    state_t                  r_state;
    logic [c_CNT_W-1:0]      r_warm_cnt;
    logic [WIDTH-1:0]        r_bin_prev;
    logic                    r_out_valid;
    logic [WIDTH-1:0]        r_out_bin;
    logic [WIDTH-1:0]        r_out_delta;
    logic [TOTAL_W-1:0]      r_total;
    logic                    r_tracking;

    logic [WIDTH-1:0]        w_gray_s;
    logic [c_GRAY_MAX_W-1:0] w_gray_ext;
    logic [WIDTH-1:0]        w_bin_s;
    logic [WIDTH-1:0]        w_delta;
    logic                    w_delta_nz;
    logic [WIDTH:0]          w_sum;
    logic [WIDTH-1:0]        w_merge;

    gray_sync #(
        .WIDTH       (WIDTH),
        .SYNC_STAGES (SYNC_STAGES)
    ) u_gray_sync (
        .clk     (clk),
        .rst_    (rst_),
        .gray_in (gray_in),
        .gray_s  (w_gray_s)
    );

    always_comb begin
        w_gray_ext               = '0;
        w_gray_ext[WIDTH-1:0]    = w_gray_s;
        w_bin_s                  = '0;
        for (int i = 0; i < WIDTH; i++) begin
            w_bin_s[i] = gray_bin_bit(w_gray_ext, i);
        end
    end

    // Modulo subtraction makes a wrap (max -> 0) read as a forward step.
    assign w_delta    = w_bin_s - r_bin_prev;
    assign w_delta_nz = (w_delta != '0);

    // One extra bit catches the carry so a stalled beat saturates.
    assign w_sum   = {1'b0, r_out_delta} + {1'b0, w_delta};
    assign w_merge = w_sum[WIDTH] ? c_SAT : w_sum[WIDTH-1:0];

    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            r_state     <= ST_WARMUP;
            r_warm_cnt  <= '0;
            r_bin_prev  <= '0;
            r_out_valid <= 1'b0;
            r_out_bin   <= '0;
            r_out_delta <= '0;
            r_total     <= '0;
            r_tracking  <= 1'b0;
        end else begin
            // bin_prev always follows bin_s: when no beat is produced the two
            // are already equal, so tracking it unconditionally is exact.
            r_bin_prev <= w_bin_s;

            if (r_state != ST_WARMUP) begin
                r_total <= r_total + TOTAL_W'(w_delta);
            end

            case (r_state)
                ST_WARMUP: begin
                    // Let the sync chain flush stale reset zeros before any
                    // difference is treated as a real count advance.
                    if (r_warm_cnt == c_WARM_LAST) begin
                        r_state    <= ST_TRACK;
                        r_tracking <= 1'b1;
                    end else begin
                        r_warm_cnt <= r_warm_cnt + c_CNT_W'(1);
                    end
                end
                ST_TRACK: begin
                    if (w_delta_nz) begin
                        r_out_bin   <= w_bin_s;
                        r_out_delta <= w_delta;
                        r_out_valid <= 1'b1;
                        r_state     <= ST_HOLD;
                    end
                end
                ST_HOLD: begin
                    if (out_ready) begin
                        if (w_delta_nz) begin
                            // Accepted beat is replaced by a fresh one holding
                            // only this cycle's advance.
                            r_out_bin   <= w_bin_s;
                            r_out_delta <= w_delta;
                        end else begin
                            r_out_valid <= 1'b0;
                            r_state     <= ST_TRACK;
                        end
                    end else if (w_delta_nz) begin
                        r_out_bin   <= w_bin_s;
                        r_out_delta <= w_merge;
                    end
                end
                default: begin
                    r_state <= ST_WARMUP;
                end
            endcase
        end
    end

`ifdef GRAY_COUNT_DECODER_ERR_CHECK_EN
    logic [WIDTH-1:0] w_gray_prev;
    logic [WIDTH-1:0] w_gray_diff;
    logic             w_err_set;
    logic             r_err;

    // Previous gray_s is re-encoded from bin_prev rather than stored again.
    assign w_gray_prev = r_bin_prev ^ (r_bin_prev >> 1);
    assign w_gray_diff = w_gray_s ^ w_gray_prev;
    // x & (x-1) is non-zero exactly when more than one bit of x is set.
    assign w_err_set   = (r_state != ST_WARMUP) &&
                         ((w_gray_diff & (w_gray_diff - WIDTH'(1))) != '0);

    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            r_err <= 1'b0;
        end else begin
            r_err <= w_err_set | (r_err & ~err_clr);
        end
    end

    assign err = r_err;
`else
    logic w_unused_err_clr;
    assign w_unused_err_clr = err_clr;
    assign err              = 1'b0;
`endif

    assign out_valid = r_out_valid;
    assign out_bin   = r_out_bin;
    assign out_delta = r_out_delta;
    assign total     = r_total;
    assign tracking  = r_tracking;

endmodule : gray_count_decoder
`default_nettype wire

// File: doc/gray_count_decoder.md
GRAY_COUNT_DECODER -- requirements
Module: gray_count_decoder

Interface
REQ-001 Parameter WIDTH, default 4: width of the incoming Gray count.
REQ-002 Parameter SYNC_STAGES, default 2, legal 2..4: synchronizer flop depth.
REQ-003 Parameter TOTAL_W, default 16: width of the running total.
REQ-004 clk  input  1  block clock; all state changes on its rising edge.
REQ-005 rst_  input  1  reset, asynchronous, active-low.
REQ-006 gray_in  input  WIDTH  Gray count from an upstream counter, asynchronous to clk.
REQ-007 out_ready  input  1  consumer accepts the current beat.
REQ-008 err_clr  input  1  clears the sticky err flag.
REQ-009 out_valid  output  1  out_bin/out_delta hold an unaccepted beat.
REQ-010 out_bin  output  WIDTH  binary value of the latest synchronized count.
REQ-011 out_delta  output  WIDTH  count advance since the previous accepted beat, saturating.
REQ-012 total  output  TOTAL_W  running sum of all deltas, modulo 2^TOTAL_W.
REQ-013 err  output  1  sticky multi-bit Gray transition flag.
REQ-014 tracking  output  1  high in TRACK or HOLD.

Function
REQ-015 gray_in SHALL pass through a SYNC_STAGES-deep flop chain; the last stage is gray_s.
REQ-016 bin_s SHALL be the Gray-to-binary decode of gray_s: bit i = XOR of gray_s bits WIDTH-1 down to i.
REQ-017 delta SHALL be (bin_s - bin_prev) modulo 2^WIDTH, so binary 15 -> 0 gives delta 1.
REQ-018 The FSM SHALL have three states: WARMUP, TRACK and HOLD.
REQ-019 WARMUP SHALL last SYNC_STAGES+1 cycles, load bin_prev <= bin_s every cycle, emit no beats, and then go to TRACK.
REQ-020 TRACK with delta != 0 SHALL load out_bin <= bin_s, out_delta <= delta, out_valid <= 1 and bin_prev <= bin_s, then go to HOLD.
REQ-021 Output latency SHALL be: out_valid rises on clock edge SYNC_STAGES+1 after a gray_in change.
REQ-022 HOLD with out_ready=0 and delta != 0 SHALL merge the change: out_bin <= bin_s, out_delta <= min(out_delta+delta, 2^WIDTH-1), bin_prev <= bin_s.
REQ-023 HOLD with out_ready=1 and delta=0 SHALL clear out_valid and go to TRACK.
REQ-024 HOLD with out_ready=1 and delta != 0 SHALL load a new beat containing only the new delta and stay in HOLD.
REQ-025 total SHALL add delta in every TRACK/HOLD cycle, independent of the handshake, and wrap at 2^TOTAL_W.
REQ-026 out_bin and out_delta SHALL stay stable while out_valid=1 and out_ready=0, except for the merge in REQ-022.

Reset
REQ-027 Asserting rst_ SHALL immediately clear the sync chain, bin_prev, out_valid, out_bin, out_delta, total, err and tracking to 0, and force the FSM to WARMUP.
REQ-028 A pending beat at reset SHALL be discarded; after rst_ deasserts the block re-enters WARMUP.

Configuration
REQ-029 Macro GRAY_COUNT_DECODER_ERR_CHECK_EN defined: in TRACK/HOLD, err SHALL set when more than one bit differs between gray_s and its previous value.
REQ-030 With that macro defined: err_clr SHALL clear err on the next edge, and a set event in the same cycle SHALL win.
REQ-031 With that macro undefined: err SHALL be tied to 0, err_clr SHALL be ignored, and no comparison logic SHALL be built.

Structure
REQ-032 A shared package gray_count_pkg SHALL hold the FSM state typedef and the Gray-to-binary decode function.
REQ-033 The synchronizer SHALL be a separate sub-module, gray_sync, parameterized by WIDTH and SYNC_STAGES.

Verification (WIDTH=4, SYNC_STAGES=2, TOTAL_W=16)
REQ-034 Reset, then gray_in 0000->0001->0011->0010, 6 cycles apart, out_ready=1 -> three beats with out_bin 1,2,3, out_delta 1 each; total=3; each out_valid rises 3 edges after its change.
REQ-035 out_ready=0, gray_in steps 0001,0011,0010,0110 -> one held beat ending with out_bin=4, out_delta=4; after out_ready=1, out_valid drops next edge.
REQ-036 Wrap: gray_in 1000 (bin 15) -> 0000 -> out_delta=1, total increments by 1.
REQ-037 Macro defined, gray_in 0000->0011 -> err=1 and stays set; err_clr pulse -> err=0; macro undefined -> err stays 0 throughout.
REQ-038 rst_ low while out_valid=1 and total=5 -> all outputs 0 at once; gray_in=0101 held at release -> no beat after WARMUP.
REQ-039 out_ready=1 in the same cycle as a new change during HOLD -> back-to-back beats, second out_delta = new change only.
